id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode stage sitting directly downstream of the IF/ID register.
- Consumes the registered PC, instruction and ready flag.
- Decodes RV32I, reads a 32x32 integer register file (written by the writeback stage), generates immediates, and registers everything into the ID/EX pipeline register.
- Detects load-use hazards and drives a stall back toward IF.

Parameters:
- XLEN, 32, datapath width.
- WB_BYPASS, 1, when 1 a same-cycle writeback to a source register is forwarded into the read data.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pc_i  in  32  PC from IF/ID.
- inst_i  in  32  instruction from IF/ID.
- ready_i  in  1  IF/ID holds a valid instruction.
- flush_i  in  1  EX redirect (taken branch/jump); kill the instruction in ID.
- ex_stall_i  in  1  downstream stall; hold the ID/EX register.
- wb_we_i  in  1  register-file write enable.
- wb_rd_i  in  5  write address.
- wb_data_i  in  32  write data.
- id_stall_o  out  1  ID cannot accept; IF/ID and PC must hold.
- ex_valid_o  out  1  ID/EX holds a live instruction.
- ex_pc_o  out  32  registered PC.
- ex_rs1_data_o  out  32  registered rs1 value.
- ex_rs2_data_o  out  32  registered rs2 value.
- ex_imm_o  out  32  sign-extended immediate.
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  5 each  register indices.
- ex_op_o  out  4  op class.
- ex_funct3_o  out  3  funct3.
- ex_funct7b5_o  out  1  inst[30].
- ex_illegal_o  out  1  undecodable opcode.

Behaviour:
- Reset (rst=0, async):
  - All ex_* outputs are 0.
  - id_stall_o is 0.
  - All 32 registers are cleared.
- Op class encoding: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP, 9 FENCE, 10 SYSTEM, 15 illegal.
  - Any other inst[6:0], or inst[1:0] != 2'b11, gives ex_op_o=15 and ex_illegal_o=1.
- Immediates:
  - I: inst[31:20] sign-extended.
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R/FENCE/SYSTEM: immediate is 0.
- Register file:
  - Two combinational read ports, one synchronous write port.
  - Writes to x0 are ignored; x0 always reads 0.
  - With WB_BYPASS=1: if wb_we_i and wb_rd_i equals the read index (nonzero), read data = wb_data_i in the same cycle.
- Source usage, for hazard purposes:
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
  - rs2 is used by BRANCH, STORE, OP.
- Load-use hazard (haz) is asserted when all of:
  - ex_valid_o=1 and ex_op_o=LOAD;
  - ex_rd_o != 0;
  - ready_i=1;
  - ex_rd_o matches a used rs1 or rs2.
- id_stall_o = haz | ex_stall_i (combinational).
- ID/EX register update, each edge, in priority order:
  1. ex_stall_i=1: hold all ID/EX contents, including while flush_i=1.
  2. flush_i=1: ex_valid_o becomes 0; other fields don't-care.
  3. haz=1: insert bubble (ex_valid_o becomes 0, other fields don't-care); instruction stays in IF/ID.
  4. Otherwise: load decoded fields; ex_valid_o becomes ready_i.
- Latency: an instruction in IF/ID with ready_i=1 appears at ex_* one cycle later (absent stall/hazard).
- A bubble costs exactly one cycle: the following edge sees ex_op_o != LOAD in a valid slot, or a bubble.
- The writeback that resolves the load updates the register file; the bypass covers same-cycle reads.
- Reset mid-stall: everything clears immediately; id_stall_o drops asynchronously.

Test Plan:
- Reset, then write x5=0x0000_1234 via writeback; present ADDI x6,x5,-1 (0xFFF28313) at pc 0x100 with ready_i=1 → next cycle:
  - ex_valid_o=1, ex_op_o=7, ex_rs1_data_o=0x1234, ex_imm_o=0xFFFFFFFF, ex_rd_o=6, ex_pc_o=0x100.
- LW x7,0(x1) followed by ADD x8,x7,x2:
  - During the ADD's first ID cycle, id_stall_o=1 and the next ex_valid_o=0.
  - One cycle later ADD enters with ex_op_o=8 and ex_rs1_o=7.
- LW x0,0(x1) followed by ADD x8,x0,x2 → no stall (rd=0 exempt).
- Bypass: wb_we_i=1, wb_rd_i=3, wb_data_i=0xDEADBEEF while SW x3,4(x2) is in ID → ex_rs2_data_o=0xDEADBEEF, ex_imm_o=4.
- Branch immediate and flush:
  - BEQ with B-immediate -8 (0xFE000CE3) → ex_imm_o=0xFFFFFFF8, ex_op_o=4.
  - Same cycle with flush_i=1 → ex_valid_o=0.
- Stall and illegal:
  - ex_stall_i=1 for 3 cycles → ex_* outputs frozen, id_stall_o=1.
  - Flush asserted under stall → ignored.
  - inst_i=0x00000000 → ex_illegal_o=1, ex_op_o=15.
  - rst pulse mid-sequence → all outputs 0 immediately.

Source files
------------

// File: rtl/id_stage.sv
// RV32I decode stage: decodes IF/ID contents, reads the register file, registers into ID/EX.
// Latency: one cycle from a ready IF/ID instruction to the ex_* outputs.
// Backpressure: ex_stall_i freezes ID/EX; a load-use hazard inserts one bubble; id_stall_o holds IF.
module id_stage #(
  parameter int XLEN      = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     pc_i,
  input  logic [31:0]     inst_i,
  input  logic            ready_i,
  input  logic            flush_i,
  input  logic            ex_stall_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            id_stall_o,
  output logic            ex_valid_o,
  output logic [31:0]     ex_pc_o,
  output logic [XLEN-1:0] ex_rs1_data_o,
  output logic [XLEN-1:0] ex_rs2_data_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [4:0]      ex_rs1_o,
  output logic [4:0]      ex_rs2_o,
  output logic [4:0]      ex_rd_o,
  output logic [3:0]      ex_op_o,
  output logic [2:0]      ex_funct3_o,
  output logic            ex_funct7b5_o,
  output logic            ex_illegal_o
);

  typedef enum logic [3:0] {
    OP_LUI    = 4'd0,
    OP_AUIPC  = 4'd1,
    OP_JAL    = 4'd2,
    OP_JALR   = 4'd3,
    OP_BRANCH = 4'd4,
    OP_LOAD   = 4'd5,
    OP_STORE  = 4'd6,
    OP_IMM    = 4'd7,
    OP_REG    = 4'd8,
    OP_FENCE  = 4'd9,
    OP_SYSTEM = 4'd10,
    OP_ILL    = 4'd15
  } op_e;

  typedef struct packed {
    logic [31:0]     pc;
    logic [XLEN-1:0] rs1_dat;
    logic [XLEN-1:0] rs2_dat;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    op_e             op;
    logic [2:0]      funct3;
    logic            funct7b5;
    logic            illegal;
  } idex_t;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  op_e         dec_op;
  logic        use_rs1, use_rs2;

  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'b0};
  assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  always_comb begin
    dec_op  = OP_ILL;
    imm32   = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    if (inst_i[1:0] == 2'b11) begin
      case (inst_i[6:2])
        5'b01101: begin dec_op = OP_LUI;    imm32 = imm_u; end
        5'b00101: begin dec_op = OP_AUIPC;  imm32 = imm_u; end
        5'b11011: begin dec_op = OP_JAL;    imm32 = imm_j; end
        5'b11001: begin dec_op = OP_JALR;   imm32 = imm_i; use_rs1 = 1'b1; end
        5'b11000: begin dec_op = OP_BRANCH; imm32 = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1; end
        5'b00000: begin dec_op = OP_LOAD;   imm32 = imm_i; use_rs1 = 1'b1; end
        5'b01000: begin dec_op = OP_STORE;  imm32 = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1; end
        5'b00100: begin dec_op = OP_IMM;    imm32 = imm_i; use_rs1 = 1'b1; end
        5'b01100: begin dec_op = OP_REG;    use_rs1 = 1'b1; use_rs2 = 1'b1; end
        5'b00011: dec_op = OP_FENCE;
        5'b11100: dec_op = OP_SYSTEM;
        default:  dec_op = OP_ILL;
      endcase
    end
  end

  // Register file: x0 is never written and is forced to zero on read.
  logic [XLEN-1:0] regs [32];
  logic [4:0]      rs1_idx, rs2_idx;
  logic [XLEN-1:0] rs1_dat, rs2_dat;

  assign rs1_idx = inst_i[19:15];
  assign rs2_idx = inst_i[24:20];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 32; k++) regs[k] <= '0;
    end else if (wb_we_i && wb_rd_i != 5'd0) begin
      regs[wb_rd_i] <= wb_data_i;
    end
  end

  always_comb begin
    rs1_dat = regs[rs1_idx];
    rs2_dat = regs[rs2_idx];
    if (WB_BYPASS && wb_we_i && wb_rd_i == rs1_idx) rs1_dat = wb_data_i;
    if (WB_BYPASS && wb_we_i && wb_rd_i == rs2_idx) rs2_dat = wb_data_i;
    if (rs1_idx == 5'd0) rs1_dat = '0;
    if (rs2_idx == 5'd0) rs2_dat = '0;
  end

  idex_t dec, ex_q;
  logic  ex_vld;
  logic  haz;

  always_comb begin
    dec          = '0;
    dec.pc       = pc_i;
    dec.rs1_dat  = rs1_dat;
    dec.rs2_dat  = rs2_dat;
    dec.imm      = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
    dec.rs1      = rs1_idx;
    dec.rs2      = rs2_idx;
    dec.rd       = inst_i[11:7];
    dec.op       = dec_op;
    dec.funct3   = inst_i[14:12];
    dec.funct7b5 = inst_i[30];
    dec.illegal  = (dec_op == OP_ILL);
  end

  assign haz = ex_vld && (ex_q.op == OP_LOAD) && (ex_q.rd != 5'd0) && ready_i &&
               ((use_rs1 && rs1_idx == ex_q.rd) || (use_rs2 && rs2_idx == ex_q.rd));

  // Gated by reset so the stall drops the moment reset asserts.
  assign id_stall_o = rst & (haz | ex_stall_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q   <= '0;
      ex_vld <= 1'b0;
    end else if (ex_stall_i) begin
      ex_q   <= ex_q;
      ex_vld <= ex_vld;
    end else if (flush_i || haz) begin
      ex_vld <= 1'b0;
    end else begin
      ex_q   <= dec;
      ex_vld <= ready_i;
    end
  end

  assign ex_valid_o    = ex_vld;
  assign ex_pc_o       = ex_q.pc;
  assign ex_rs1_data_o = ex_q.rs1_dat;
  assign ex_rs2_data_o = ex_q.rs2_dat;
  assign ex_imm_o      = ex_q.imm;
  assign ex_rs1_o      = ex_q.rs1;
  assign ex_rs2_o      = ex_q.rs2;
  assign ex_rd_o       = ex_q.rd;
  assign ex_op_o       = ex_q.op;
  assign ex_funct3_o   = ex_q.funct3;
  assign ex_funct7b5_o = ex_q.funct7b5;
  assign ex_illegal_o  = ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i, inst_i;
  logic        ready_i, flush_i, ex_stall_i, wb_we_i;
  logic [4:0]  wb_rd_i;
  logic [31:0] wb_data_i;
  logic        id_stall_o, ex_valid_o;
  logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [3:0]  ex_op_o;
  logic [2:0]  ex_funct3_o;
  logic        ex_funct7b5_o, ex_illegal_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32), .WB_BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .ready_i(ready_i),
    .flush_i(flush_i), .ex_stall_i(ex_stall_i), .wb_we_i(wb_we_i), .wb_rd_i(wb_rd_i),
    .wb_data_i(wb_data_i), .id_stall_o(id_stall_o), .ex_valid_o(ex_valid_o),
    .ex_pc_o(ex_pc_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_imm_o(ex_imm_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
    .ex_op_o(ex_op_o), .ex_funct3_o(ex_funct3_o), .ex_funct7b5_o(ex_funct7b5_o),
    .ex_illegal_o(ex_illegal_o)
  );

  // Behavioural model: architectural registers plus the expected ID/EX slot.
  logic [31:0] m_regs [32];
  bit          m_valid, m_known;
  logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [3:0]  m_op;
  logic [2:0]  m_f3;
  logic        m_f7, m_ill;

  localparam logic [6:0] OPC_TBL [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                          7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  function automatic int m_cls(input logic [31:0] i);
    for (int k = 0; k < 11; k++) if (i[6:0] == OPC_TBL[k]) return k;
    return 15;
  endfunction

  function automatic logic [31:0] m_immf(input logic [31:0] i, input int c);
    int s;
    s = i[31] ? 1 : 0;
    case (c)
      0, 1:    return {i[31:12], 12'h000};
      2:       return -s * (1 << 20) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      3, 5, 7: return -s * 2048 + int'(i[30:20]);
      4:       return -s * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      6:       return -s * 2048 + int'(i[30:25]) * 32 + int'(i[11:7]);
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 0;
    if (wb_we_i && wb_rd_i == a) return wb_data_i;
    return m_regs[a];
  endfunction

  function automatic bit m_haz();
    int c;
    bit r1, r2;
    c  = m_cls(inst_i);
    r1 = (c inside {3, 4, 5, 6, 7, 8}) && inst_i[19:15] == m_rd;
    r2 = (c inside {4, 6, 8}) && inst_i[24:20] == m_rd;
    return m_valid && m_op == 4'd5 && m_rd != 0 && ready_i && (r1 || r2);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) m_regs[k] = 0;
    m_valid = 0; m_known = 1; m_pc = 0; m_rs1d = 0; m_rs2d = 0; m_imm = 0;
    m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op = 0; m_f3 = 0; m_f7 = 0; m_ill = 0;
  endtask

  task automatic model_edge();
    int c;
    if (!rst) return;
    c = m_cls(inst_i);
    if (!ex_stall_i) begin
      if (flush_i || m_haz()) begin
        m_valid = 0; m_known = 0;
      end else begin
        m_valid = ready_i; m_known = 1; m_pc = pc_i;
        m_rs1d = m_read(inst_i[19:15]); m_rs2d = m_read(inst_i[24:20]);
        m_imm = m_immf(inst_i, c); m_rs1 = inst_i[19:15]; m_rs2 = inst_i[24:20];
        m_rd = inst_i[11:7]; m_op = 4'(c); m_f3 = inst_i[14:12]; m_f7 = inst_i[30];
        m_ill = (c == 15);
      end
    end
    if (wb_we_i && wb_rd_i != 0) m_regs[wb_rd_i] = wb_data_i;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ready_i = 0; flush_i = 0; ex_stall_i = 0; wb_we_i = 0; wb_rd_i = 0; wb_data_i = 0;
  endtask

  task automatic test_reset();
    rst = 0; pc_i = 0; inst_i = 0; idle(); ex_stall_i = 1;
    model_reset();
    #3;
    checks++; if (id_stall_o !== 1'b0) begin failures++; $display("FAIL reset_id_stall got %b want 0", id_stall_o); end
    checks++;
    if ({ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rs1_o, ex_rs2_o, ex_rd_o,
         ex_op_o, ex_funct3_o, ex_funct7b5_o, ex_illegal_o} !== '0) begin
      failures++; $display("FAIL reset_ex_outputs got valid=%b pc=%h op=%h imm=%h want all 0",
                           ex_valid_o, ex_pc_o, ex_op_o, ex_imm_o);
    end
    #4; rst = 1; ex_stall_i = 0;
    tick();
  endtask

  task automatic test_addi();
    wb_we_i = 1; wb_rd_i = 5; wb_data_i = 32'h0000_1234;
    tick();
    wb_we_i = 0; pc_i = 32'h100; inst_i = 32'hFFF28313; ready_i = 1;
    tick();
    checks++; if (ex_valid_o !== 1'b1 || ex_op_o !== 4'd7) begin failures++; $display("FAIL addi_valid_op got %b/%0d want 1/7", ex_valid_o, ex_op_o); end
    checks++; if (ex_rs1_data_o !== 32'h1234) begin failures++; $display("FAIL addi_rs1_data got %h want 00001234", ex_rs1_data_o); end
    checks++; if (ex_imm_o !== 32'hFFFFFFFF) begin failures++; $display("FAIL addi_imm got %h want ffffffff", ex_imm_o); end
    checks++; if (ex_rd_o !== 5'd6 || ex_pc_o !== 32'h100) begin failures++; $display("FAIL addi_rd_pc got %0d/%h want 6/100", ex_rd_o, ex_pc_o); end
  endtask

  task automatic test_load_use();
    pc_i = 32'h104; inst_i = 32'h0000A383; ready_i = 1;
    tick();
    pc_i = 32'h108; inst_i = 32'h00238433;
    #1;
    checks++; if (id_stall_o !== 1'b1) begin failures++; $display("FAIL load_use_stall got %b want 1", id_stall_o); end
    tick();
    checks++; if (ex_valid_o !== 1'b0) begin failures++; $display("FAIL load_use_bubble got %b want 0", ex_valid_o); end
    checks++; if (id_stall_o !== 1'b0) begin failures++; $display("FAIL load_use_release got %b want 0", id_stall_o); end
    tick();
    checks++; if (ex_valid_o !== 1'b1 || ex_op_o !== 4'd8 || ex_rs1_o !== 5'd7) begin
      failures++; $display("FAIL load_use_add got valid=%b op=%0d rs1=%0d want 1/8/7", ex_valid_o, ex_op_o, ex_rs1_o);
    end
  endtask

  task automatic test_load_x0();
    inst_i = 32'h0000A003; ready_i = 1;
    tick();
    inst_i = 32'h00200433;
    #1;
    checks++; if (id_stall_o !== 1'b0) begin failures++; $display("FAIL load_x0_stall got %b want 0", id_stall_o); end
    tick();
    checks++; if (ex_valid_o !== 1'b1 || ex_op_o !== 4'd8) begin failures++; $display("FAIL load_x0_add got %b/%0d want 1/8", ex_valid_o, ex_op_o); end
  endtask

  task automatic test_bypass();
    inst_i = 32'h00312223; ready_i = 1;
    wb_we_i = 1; wb_rd_i = 3; wb_data_i = 32'hDEADBEEF;
    tick();
    wb_we_i = 0;
    checks++; if (ex_rs2_data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_rs2 got %h want deadbeef", ex_rs2_data_o); end
    checks++; if (ex_imm_o !== 32'd4 || ex_op_o !== 4'd6) begin failures++; $display("FAIL bypass_imm_op got %h/%0d want 4/6", ex_imm_o, ex_op_o); end
    tick();
    checks++; if (ex_rs2_data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL regfile_persist got %h want deadbeef", ex_rs2_data_o); end
  endtask

  task automatic test_branch_flush();
    inst_i = 32'hFE000CE3; ready_i = 1;
    tick();
    checks++; if (ex_imm_o !== 32'hFFFFFFF8 || ex_op_o !== 4'd4) begin failures++; $display("FAIL branch_imm got %h/%0d want fffffff8/4", ex_imm_o, ex_op_o); end
    flush_i = 1;
    tick();
    flush_i = 0;
    checks++; if (ex_valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid got %b want 0", ex_valid_o); end
  endtask

  task automatic test_stall();
    pc_i = 32'h200; inst_i = 32'hFFF28313; ready_i = 1;
    tick();
    ex_stall_i = 1; pc_i = 32'h204; inst_i = 32'h00238433;
    for (int i = 0; i < 3; i++) begin
      flush_i = (i == 1);
      #1;
      checks++; if (id_stall_o !== 1'b1) begin failures++; $display("FAIL stall_id_stall[%0d] got %b want 1", i, id_stall_o); end
      tick();
      checks++; if (ex_valid_o !== 1'b1 || ex_pc_o !== 32'h200 || ex_imm_o !== 32'hFFFFFFFF || ex_op_o !== 4'd7) begin
        failures++; $display("FAIL stall_hold[%0d] got valid=%b pc=%h imm=%h op=%0d want 1/200/ffffffff/7", i, ex_valid_o, ex_pc_o, ex_imm_o, ex_op_o);
      end
    end
    ex_stall_i = 0; flush_i = 0;
  endtask

  task automatic test_illegal();
    inst_i = 32'h0000_0000; ready_i = 1;
    tick();
    checks++; if (ex_illegal_o !== 1'b1 || ex_op_o !== 4'd15) begin failures++; $display("FAIL illegal_zero got %b/%0d want 1/15", ex_illegal_o, ex_op_o); end
    inst_i = 32'h0000_0011;
    tick();
    checks++; if (ex_illegal_o !== 1'b1 || ex_op_o !== 4'd15) begin failures++; $display("FAIL illegal_low2 got %b/%0d want 1/15", ex_illegal_o, ex_op_o); end
  endtask

  task automatic test_random();
    logic [31:0] i;
    bit exp_stall;
    int k;
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 12);
      i = $urandom;
      i[6:0] = (k < 11) ? OPC_TBL[k] : 7'($urandom);
      i[11:7] = 5'($urandom_range(0, 7));
      i[19:15] = 5'($urandom_range(0, 7));
      i[24:20] = 5'($urandom_range(0, 7));
      inst_i = i; pc_i = $urandom;
      ready_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 7) == 0);
      ex_stall_i = ($urandom_range(0, 5) == 0);
      wb_we_i = $urandom_range(0, 1); wb_rd_i = 5'($urandom_range(0, 7)); wb_data_i = $urandom;
      #1;
      exp_stall = m_haz() || ex_stall_i;
      checks++; if (id_stall_o !== exp_stall) begin failures++; $display("FAIL rand_stall[%0d] got %b want %b", n, id_stall_o, exp_stall); end
      tick();
      checks++; if (ex_valid_o !== m_valid) begin failures++; $display("FAIL rand_valid[%0d] got %b want %b", n, ex_valid_o, m_valid); end
      if (m_known) begin
        checks++;
        if ({ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o} !== {m_pc, m_rs1d, m_rs2d, m_imm}) begin
          failures++; $display("FAIL rand_data[%0d] got pc=%h a=%h b=%h imm=%h want pc=%h a=%h b=%h imm=%h",
                               n, ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, m_pc, m_rs1d, m_rs2d, m_imm);
        end
        checks++;
        if ({ex_rs1_o, ex_rs2_o, ex_rd_o, ex_op_o, ex_funct3_o, ex_funct7b5_o, ex_illegal_o} !==
            {m_rs1, m_rs2, m_rd, m_op, m_f3, m_f7, m_ill}) begin
          failures++; $display("FAIL rand_ctl[%0d] got rs=%0d/%0d rd=%0d op=%0d f3=%0d f7=%b ill=%b want rs=%0d/%0d rd=%0d op=%0d f3=%0d f7=%b ill=%b",
                               n, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_op_o, ex_funct3_o, ex_funct7b5_o, ex_illegal_o,
                               m_rs1, m_rs2, m_rd, m_op, m_f3, m_f7, m_ill);
        end
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    wb_we_i = 1; wb_rd_i = 5; wb_data_i = 32'h55;
    pc_i = 32'h300; inst_i = 32'hFFF28313; ready_i = 1;
    tick();
    wb_we_i = 0; ex_stall_i = 1;
    #2; rst = 0; #1;
    model_reset();
    checks++; if (id_stall_o !== 1'b0) begin failures++; $display("FAIL midreset_stall got %b want 0", id_stall_o); end
    checks++; if ({ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_imm_o, ex_op_o, ex_rd_o} !== '0) begin
      failures++; $display("FAIL midreset_outputs got valid=%b pc=%h rs1d=%h imm=%h op=%0d rd=%0d want 0",
                           ex_valid_o, ex_pc_o, ex_rs1_data_o, ex_imm_o, ex_op_o, ex_rd_o);
    end
    ex_stall_i = 0;
    #2; rst = 1;
    tick();
    checks++; if (ex_valid_o !== 1'b1 || ex_rs1_data_o !== 32'h0) begin
      failures++; $display("FAIL midreset_regs_cleared got valid=%b rs1d=%h want 1/0", ex_valid_o, ex_rs1_data_o);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_load_x0();
    test_bypass();
    test_branch_flush();
    test_stall();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
